// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared RSA datapath types: modexp FSM states and default operand width
package rsa_pkg;

  localparam int DEFAULT_WIDTH = 6;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SQUARE,
    MULT,
    DONE
  } modexp_state_t;

  // Width of a bit index into a w-bit operand, never narrower than one bit.
  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mod_exp_ctrl_if.sv
// rtl/mod_exp_ctrl_if.sv - request, reducer and result signals of the modexp controller
interface mod_exp_ctrl_if #(
  parameter int WIDTH = rsa_pkg::DEFAULT_WIDTH
) ();

  logic               start;
  logic [WIDTH-1:0]   base;
  logic [WIDTH-1:0]   exp;
  logic [WIDTH-1:0]   N;
  logic [2*WIDTH-1:0] out_mul;
  logic               Continue;
  logic [WIDTH-1:0]   red_in;
  logic [WIDTH-1:0]   result;
  logic               done;
  logic               busy;
  logic               err;

  // master: requester plus the combinational reducer; slave: the controller
  modport master (
    output start, base, exp, N, red_in,
    input  out_mul, Continue, result, done, busy, err
  );

  modport slave (
    input  start, base, exp, N, red_in,
    output out_mul, Continue, result, done, busy, err
  );

endinterface

// File: rtl/exp_msb_find.sv
// rtl/exp_msb_find.sv - priority encoder giving the highest set bit of the exponent
module exp_msb_find #(
  parameter int WIDTH = 6,
  parameter int IW    = 3
) (
  input  logic [WIDTH-1:0] exp,
  output logic [IW-1:0]    msb,
  output logic             zero
);

  always_comb begin
    msb  = '0;
    zero = (exp == '0);
    for (int k = 0; k < WIDTH; k++) begin
      if (exp[k]) msb = IW'(k);
    end
  end

endmodule

// File: rtl/mod_exp_ctrl.sv
// rtl/mod_exp_ctrl.sv - square-and-multiply base^exp mod N controller around an external reducer
// Optional MODEXP_LEADING_SKIP_EN starts the scan at the exponent's highest set bit.
module mod_exp_ctrl
  import rsa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  mod_exp_ctrl_if.slave   bus
);

  localparam int IW = idx_width(WIDTH);
  localparam int W2 = 2 * WIDTH;

  modexp_state_t    state_q, state_d;
  logic [WIDTH-1:0] base_q, exp_q, n_q, acc_q, b_q, result_q;
  logic [IW-1:0]    idx_q, idx_init;
  logic             err_q;
  logic [W2-1:0]    out_mul_c;
  logic             cont_c, done_c, accept, dec_idx;

`ifdef MODEXP_LEADING_SKIP_EN
  logic [IW-1:0] msb_idx;
  logic          exp_zero, zero_q;

  exp_msb_find #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_msb (
    .exp  (bus.exp),
    .msb  (msb_idx),
    .zero (exp_zero)
  );

  assign idx_init = msb_idx;
`else
  assign idx_init = IW'(WIDTH - 1);
`endif

  always_comb begin
    state_d   = state_q;
    out_mul_c = '0;
    cont_c    = 1'b0;
    done_c    = 1'b0;
    accept    = 1'b0;
    dec_idx   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        done_c  = (state_q == DONE);
        state_d = IDLE;
        if (bus.start) begin
          accept  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cont_c    = 1'b1;
        out_mul_c = W2'(base_q);
        state_d   = SQUARE;
`ifdef MODEXP_LEADING_SKIP_EN
        if (zero_q) state_d = DONE;
`endif
        if (n_q == '0) state_d = DONE;
      end
      SQUARE: begin
        cont_c    = 1'b1;
        out_mul_c = W2'(acc_q) * W2'(acc_q);
        if (exp_q[idx_q]) begin
          state_d = MULT;
        end else if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          dec_idx = 1'b1;
          state_d = SQUARE;
        end
      end
      MULT: begin
        cont_c    = 1'b1;
        out_mul_c = W2'(acc_q) * W2'(b_q);
        if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          dec_idx = 1'b1;
          state_d = SQUARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      exp_q    <= '0;
      n_q      <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
`ifdef MODEXP_LEADING_SKIP_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        base_q <= bus.base;
        exp_q  <= bus.exp;
        n_q    <= bus.N;
        acc_q  <= (bus.N == WIDTH'(1)) ? '0 : WIDTH'(1);
        idx_q  <= idx_init;
        err_q  <= 1'b0;
`ifdef MODEXP_LEADING_SKIP_EN
        zero_q <= exp_zero;
`endif
      end
      case (state_q)
        LOAD: begin
          b_q <= bus.red_in;
          // Early exits from LOAD: modulus zero, or nothing to scan.
          if (state_d == DONE) begin
            result_q <= (n_q == '0) ? '0 : acc_q;
            err_q    <= (n_q == '0);
          end
        end
        SQUARE, MULT: begin
          acc_q <= bus.red_in;
          if (dec_idx) idx_q <= idx_q - IW'(1);
          if (state_d == DONE) result_q <= bus.red_in;
        end
        default: ;
      endcase
    end
  end

  assign bus.out_mul  = out_mul_c;
  assign bus.Continue = cont_c;
  assign bus.busy     = cont_c;
  assign bus.done     = done_c;
  assign bus.result   = result_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// tb/tb_mod_exp_ctrl.sv - self-checking bench for mod_exp_ctrl with an ideal reducer
module tb_mod_exp_ctrl;

  localparam int WIDTH = 6;
`ifdef MODEXP_LEADING_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mod_exp_ctrl_if #(.WIDTH(WIDTH)) bus ();

  mod_exp_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Ideal reducer against the modulus of the request the bench launched.
  logic [WIDTH-1:0] ref_n;
  always_comb bus.red_in = (ref_n == '0) ? '0 : WIDTH'(bus.out_mul % ref_n);

  int n_pass   = 0;
  int n_checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  always @(negedge clk) check("continue_eq_busy", 32'(bus.Continue), 32'(bus.busy));

  function automatic int ref_modexp(input int b, input int e, input int n);
    int r;
    if (n == 0) return 0;
    r = 1 % n;
    for (int k = 0; k < e; k++) r = (r * b) % n;
    return r;
  endfunction

  function automatic int ref_lat(input int e, input int n);
    int msb;
    if (n == 0) return 1;
    if (!SKIP) return 1 + WIDTH + $countones(e);
    if (e == 0) return 1;
    msb = 0;
    for (int k = 0; k < WIDTH; k++) if (((e >> k) & 1) == 1) msb = k;
    return 1 + (msb + 1) + $countones(e);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int b, input int e, input int n);
    bus.base  = WIDTH'(b);
    bus.exp   = WIDTH'(e);
    bus.N     = WIDTH'(n);
    ref_n     = WIDTH'(n);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int already, output int lat);
    lat = already;
    do begin
      step();
      lat++;
    end while (!bus.done && lat < 200);
    if (!bus.done) lat = 999;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_mul"},  32'(bus.out_mul),  0);
    check({tag, "_continue"}, 32'(bus.Continue), 0);
    check({tag, "_result"},   32'(bus.result),   0);
    check({tag, "_done"},     32'(bus.done),     0);
    check({tag, "_busy"},     32'(bus.busy),     0);
    check({tag, "_err"},      32'(bus.err),      0);
  endtask

  task automatic run_case(input string tag, input int b, input int e, input int n,
                          input int res, input int er, input int lat_req);
    int lat;
    launch(b, e, n);
    check({tag, "_err_clr"}, 32'(bus.err), 0);
    wait_done(0, lat);
    check({tag, "_latency"}, lat, lat_req);
    check({tag, "_result"},  32'(bus.result), res);
    check({tag, "_err"},     32'(bus.err), er);
    step();
    check({tag, "_done_pulse"}, 32'(bus.done), 0);
  endtask

  typedef struct {
    int b, e, n, res, er, lat_plain, lat_skip;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int   lat;
    int   done_seen;

    vecs[0] = '{4, 13, 33, 31, 0, 10, 8};
    vecs[1] = '{50, 1, 7, 1, 0, 8, 3};
    vecs[2] = '{5, 0, 7, 1, 0, 7, 1};
    vecs[3] = '{9, 5, 1, 0, 0, 9, 6};
    vecs[4] = '{3, 5, 0, 0, 1, 1, 1};

    bus.start = 1'b0;
    bus.base  = '0;
    bus.exp   = '0;
    bus.N     = '0;
    ref_n     = WIDTH'(1);
    rst       = 1'b1;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    for (int k = 0; k < 5; k++)
      run_case($sformatf("vec%0d", k), vecs[k].b, vecs[k].e, vecs[k].n, vecs[k].res,
               vecs[k].er, SKIP ? vecs[k].lat_skip : vecs[k].lat_plain);

    // start pulsed mid-run with other operands must not disturb the run
    launch(4, 13, 33);
    step();
    step();
    bus.base  = WIDTH'(7);
    bus.exp   = WIDTH'(63);
    bus.N     = WIDTH'(11);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done(3, lat);
    check("midstart_latency", lat, SKIP ? 8 : 10);
    check("midstart_result", 32'(bus.result), 31);
    step();

    // start held during DONE is accepted without an IDLE cycle
    launch(5, 0, 7);
    wait_done(0, lat);
    check("b2b_first_result", 32'(bus.result), 1);
    bus.base  = WIDTH'(4);
    bus.exp   = WIDTH'(13);
    bus.N     = WIDTH'(33);
    ref_n     = WIDTH'(33);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("b2b_no_idle_gap", 32'(bus.busy), 1);
    wait_done(0, lat);
    check("b2b_latency", lat, SKIP ? 8 : 10);
    check("b2b_result", 32'(bus.result), 31);
    step();

    // reset four edges into a run aborts it
    launch(4, 13, 33);
    repeat (3) step();
    rst = 1'b1;
    step();
    check_all_zero("midrst");
    rst = 1'b0;
    done_seen = 0;
    repeat (15) begin
      step();
      if (bus.done) done_seen++;
    end
    check("midrst_no_done", done_seen, 0);
    run_case("after_rst", 50, 1, 7, 1, 0, ref_lat(1, 7));

    for (int k = 0; k < 60; k++) begin
      int b, e, n;
      b = int'($urandom_range(0, 63));
      e = int'($urandom_range(0, 63));
      n = int'($urandom_range(1, 63));
      run_case($sformatf("rnd%0d_b%0d_e%0d_n%0d", k, b, e, n), b, e, n,
               ref_modexp(b, e, n), 0, ref_lat(e, n));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mod_exp_ctrl.md
# mod_exp_ctrl

Sequential square-and-multiply controller that computes `base^exp mod N` for the RSA datapath. It sits on both sides of the combinational modular reducer. It drives the double-width product into the reducer (`out_mul`, `Continue`) and consumes the reduced remainder on the next state update. One modular step completes per clock, and the final value is presented on `result` with a one-cycle `done` pulse.

## Interface
- `WIDTH`, default 6: operand width (base, exponent, modulus, result).
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request; accepted only in IDLE or DONE.
- `base`  in  WIDTH: message/base operand, latched on accept.
- `exp`  in  WIDTH: exponent, latched on accept.
- `N`  in  WIDTH: modulus, latched on accept.
- `out_mul`  out  2*WIDTH: product presented to the reducer.
- `Continue`  out  1: reducer enable; high in LOAD/SQUARE/MULT.
- `red_in`  in  WIDTH: reducer output; must equal `out_mul mod N` combinationally in the same cycle.
- `result`  out  WIDTH: final remainder, held until the next accept.
- `done`  out  1: one-cycle pulse when `result` is valid.
- `busy`  out  1: high in LOAD/SQUARE/MULT.
- `err`  out  1: set with `done` when `N == 0`; cleared on the next accept.

## Operation
- States:
  - IDLE, LOAD, SQUARE, MULT, DONE.
- IDLE/DONE + `start`:
  - Latch `base`, `exp` and `N`.
  - Set `acc = (N==1) ? 0 : 1`.
  - Set bit index `i = WIDTH-1`.
  - Go to LOAD.
  - If the latched `N == 0`, go directly to DONE with `err=1` and `result=0`.
- LOAD:
  - `out_mul = zero-extended base`; capture `b <= red_in` (base mod N).
  - Next state is SQUARE.
- SQUARE:
  - `out_mul = acc*acc`, full 2*WIDTH product with no truncation; `acc <= red_in`.
  - If `exp[i]`, go to MULT.
  - Otherwise, if `i==0`, go to DONE; else decrement `i` and go to SQUARE.
- MULT:
  - `out_mul = acc*b`; `acc <= red_in`.
  - If `i==0`, go to DONE; else decrement `i` and go to SQUARE.
- DONE:
  - `result <= acc` (registered on entry) and `done=1` for this cycle only.
  - Next state is IDLE unless `start` is high, which is accepted as from IDLE.
- Exponent bits are processed MSB first.
- `start` in LOAD/SQUARE/MULT is ignored, and input changes while busy have no effect.
- `out_mul = 0` and `Continue = 0` in IDLE/DONE.

## Timing
- Reset value of every output is 0: `out_mul`, `Continue`, `result`, `done`, `busy`, `err`. State returns to IDLE.
- `rst` mid-operation aborts in the same edge. No `done` is produced for the aborted request.
- Latency from the accepting edge to `done` visible is `1 + B + P` edges:
  - B = number of exponent bits scanned (WIDTH by default).
  - P = popcount(exp).
- `N==0`: `done` is visible 1 edge after accept.
- Throughput is one request per `1 + B + P + 1` cycles. A back-to-back `start` during DONE saves the IDLE cycle.

## Configuration
- `MODEXP_LEADING_SKIP_EN` defined:
  - On accept, `i` is loaded with the index of the highest set bit of `exp`, so B = msb index + 1.
  - If `exp == 0`, LOAD goes directly to DONE (B=0) and `result = acc` init.
- Not defined:
  - B = WIDTH always; leading zeros cost one SQUARE cycle each.
- The result value is identical either way.

## Structure
- Shared package `rsa_pkg`:
  - State enum `modexp_state_t` (IDLE, LOAD, SQUARE, MULT, DONE).
  - Default `WIDTH` constant.
- Sub-module `exp_msb_find`: combinational priority encoder on `exp` giving msb index and zero flag. Instantiated only under `MODEXP_LEADING_SKIP_EN`.

## Test plan
All scenarios use an ideal combinational reducer model, WIDTH=6.
- base=4, exp=13, N=33, no macro -> `result=31`, `done` 10 edges after accept; with macro -> 8 edges.
- base=50, exp=1, N=7 -> `result=1` (base reduced in LOAD). base=5, exp=0, N=7 -> `result=1`, 7 edges without macro, 1 with macro.
- N=1, base=9, exp=5 -> `result=0`, `err=0`. N=0 -> `err=1`, `result=0`, `done` 1 edge after accept.
- `start` pulsed again mid-run with different operands -> ignored, first result (31 for case 1) unchanged. `start` held in the DONE cycle -> second request accepted with no IDLE gap.
- `rst` asserted 4 edges into a run -> all outputs 0 next cycle, no `done`. A fresh request afterwards completes correctly.
- Random sweep of all base/exp/N with N≥1 against a reference model; `Continue == busy` every cycle.
